// File: rtl/hilo_muldiv_pkg.sv
// Shared ALU control codes, FSM state encoding and decode helpers for hilo_muldiv.
package hilo_muldiv_pkg;

    localparam logic [4:0] ADD_CONTROL   = 5'b00010;
    localparam logic [4:0] MULT_CONTROL  = 5'b11000;
    localparam logic [4:0] MULTU_CONTROL = 5'b11001;
    localparam logic [4:0] DIV_CONTROL   = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] code);
        return (code == MULT_CONTROL) || (code == MULTU_CONTROL) ||
               (code == DIV_CONTROL)  || (code == DIVU_CONTROL);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] code);
        return (code == MULT_CONTROL) || (code == DIV_CONTROL);
    endfunction

    function automatic logic is_div_op(input logic [4:0] code);
        return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/hilo_muldiv_core.sv
// Unsigned WIDTH-step datapath: shift-add multiply or restoring divide on one shared
// 2*WIDTH accumulator, with the step counter that paces the CALC phase.
module hilo_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               op_is_div,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic               last,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;

    // Multiply keeps the multiplier in the low half and shifts the partial product in from
    // the top; divide shifts the dividend out of the low half into the remainder.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_next = acc;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_q : '0)};
        trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
        if (op_is_div) begin
            if (trial[WIDTH])
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            else
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            b_q <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, a_mag};
            b_q <= b_mag;
            cnt <= CW'(WIDTH - 1);
        end else if (step) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
        end
    end

    assign last      = (cnt == '0);
    assign product   = acc;
    assign quotient  = acc[WIDTH-1:0];
    assign remainder = acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers; owns the FSM,
// operand sign handling, flush and MTHI/MTLO writes. busy stalls the pipeline.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state, next_state;

    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               sa, sb, op_is_div, div_by_zero;
    logic               last;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign accept    = start & is_muldiv(alu_control) & (state == IDLE) & ~flush;
    assign busy      = (state != IDLE) | accept;
    assign signed_op = is_signed_op(alu_control);
    assign a_mag     = (signed_op & a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op & b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CALC;
            CALC:    if (flush) next_state = IDLE;
                     else if (last) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa          <= 1'b0;
            sb          <= 1'b0;
            op_is_div   <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            sa          <= signed_op & a[WIDTH-1];
            sb          <= signed_op & b[WIDTH-1];
            op_is_div   <= is_div_op(alu_control);
            div_by_zero <= (b == '0);
        end
    end

    hilo_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .step      ((state == CALC) & ~flush),
        .op_is_div (op_is_div),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .last      (last),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Divide by zero leaves the remainder equal to |a|, so the normal remainder fixup
    // already restores HI = a; only the quotient is forced to all ones.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (op_is_div) begin
            res_lo = div_by_zero ? '1 : ((sa ^ sb) ? -quotient : quotient);
            res_hi = sa ? -remainder : remainder;
        end else begin
            {res_hi, res_lo} = (sa ^ sb) ? -product : product;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX) & ~flush;
            if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end else if ((state == FIX) && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: a reference model pushes expected {HI,LO} on every
// accepted op and a monitor pops and compares them on each done pulse.
module tb_hilo_muldiv;
    import hilo_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  alu_control;
    logic [31:0] a, b;
    logic        flush;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
        longint p;
        int     qa, qb;
        logic [63:0] r;
        r = '0;
        case (op)
            MULT_CONTROL: begin
                p = longint'($signed(av)) * longint'($signed(bv));
                r = 64'(p);
            end
            MULTU_CONTROL: r = {32'b0, av} * {32'b0, bv};
            DIV_CONTROL: begin
                if (bv == 32'h0)
                    r = {av, 32'hFFFF_FFFF};
                else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)
                    r = {32'h0, 32'h8000_0000};
                else begin
                    qa = $signed(av);
                    qb = $signed(bv);
                    r = {32'(qa % qb), 32'(qa / qb)};
                end
            end
            DIVU_CONTROL: r = (bv == 32'h0) ? {av, 32'hFFFF_FFFF} : {av % bv, av / bv};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Scoreboard monitor: every done must have a pending expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", {63'b0, done}, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("hilo_result", {hi, lo}, e);
            end
        end
    end

    // Called at a negedge (or just after); drives one op and follows it to its done pulse.
    task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                          output logic [63:0] pre_hilo);
        int busy_cycles;
        bit seen;
        start = 1'b1; alu_control = op; a = av; b = bv;
        sb_q.push_back(model(op, av, bv));
        #1;
        busy_cycles = busy ? 1 : 0;
        seen = 1'b0;
        pre_hilo = '0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            #1;
            if (i == 33) pre_hilo = {hi, lo};
            if (done) begin
                seen = 1'b1;
                check("done_latency", 64'(i), 64'd34);
                check("busy_at_done", {63'b0, busy}, 64'd0);
                break;
            end
            if (busy) busy_cycles++;
        end
        check("done_seen", {63'b0, seen}, 64'd1);
        check("busy_cycles", 64'(busy_cycles), 64'd34);
    endtask

    initial begin
        logic [63:0] pre;
        logic [63:0] saved;
        logic [4:0]  ops [4];
        ops[0] = MULT_CONTROL; ops[1] = MULTU_CONTROL; ops[2] = DIV_CONTROL; ops[3] = DIVU_CONTROL;

        rst = 1'b1; start = 1'b0; alu_control = '0; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, issued back to back.
        run_op(MULT_CONTROL,  32'hFFFF_FFFF, 32'd2, pre);
        run_op(MULTU_CONTROL, 32'hFFFF_FFFF, 32'd2, pre);
        run_op(DIV_CONTROL,   32'hFFFF_FFF9, 32'd2, pre);
        run_op(DIVU_CONTROL,  32'd7,         32'd0, pre);
        run_op(DIV_CONTROL,   32'h8000_0000, 32'hFFFF_FFFF, pre);
        run_op(DIV_CONTROL,   32'hFFFF_FFFB, 32'd0, pre);

        // MTHI in IDLE, then MULT: HI holds until the result edge.
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0;
        #1 check("mthi_idle", {32'b0, hi}, 64'h1234);
        run_op(MULT_CONTROL, 32'd3, 32'd4, pre);
        check("mthi_hold", {32'b0, pre[63:32]}, 64'h1234);

        // MTLO in the accept cycle lands now and is overwritten by the result.
        lo_we = 1'b1; wdata = 32'hABCD;
        run_op(MULTU_CONTROL, 32'd5, 32'd6, pre);
        check("mtlo_with_accept", {32'b0, pre[31:0]}, 64'hABCD);

        // Non-muldiv code with start is ignored.
        start = 1'b1; alu_control = ADD_CONTROL; a = 32'd1; b = 32'd1;
        #1 check("add_not_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1 check("add_hilo_same", {hi, lo}, 64'd30);

        // Flush in cycle k+10 of a DIV, then a new MULT at k+11.
        @(negedge clk);
        saved = {hi, lo};
        start = 1'b1; alu_control = DIV_CONTROL; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_idle", {63'b0, busy}, 64'd0);
        check("flush_hilo", {hi, lo}, saved);
        run_op(MULT_CONTROL, 32'hFFFF_FFF9, 32'd6, pre);

        // Random mix of all four operations.
        for (int n = 0; n < 8; n++) begin
            run_op(ops[n % 4], $urandom, (n == 5) ? 32'd0 : $urandom, pre);
        end

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; alu_control = MULTU_CONTROL; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1; alu_control = ADD_CONTROL;
        #1 check("rst_add_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        start = 1'b0;
        #1;
        check("rst_no_result", {hi, lo}, 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core's execute stage. It consumes the 5-bit ALU control code produced by the ALU decoder and executes MULT/MULTU/DIV/DIVU over 33 cycles. While it works it stalls the pipeline through `busy`. HI/LO also accept MTHI/MTLO writes and feed MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: execute stage presents a valid instruction this cycle.
- `alu_control` in 5: ALU control code; only `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL` and `DIVU_CONTROL` are acted on.
- `a`, `b` in `WIDTH`: rs and rt operands (dividend and divisor for divides).
- `flush` in 1: abort any in-flight operation.
- `hi_we`, `lo_we` in 1: MTHI/MTLO write enables.
- `wdata` in `WIDTH`: MTHI/MTLO data.
- `busy` out 1: combinational; `(state != IDLE) | accept`. Drives the pipeline stall.
- `done` out 1: registered; one-cycle pulse when HI/LO take a result.
- `hi`, `lo` out `WIDTH`: current HI/LO register contents.

## Operation
- States: IDLE, CALC, FIX.
- `accept = start & is_muldiv(alu_control) & state==IDLE & ~flush`.
- On accept, latch:
  - sign flags (signed ops only): `sa = a[31]`, `sb = b[31]`;
  - operand magnitudes: |a| and |b| for signed ops, raw values for unsigned ops;
  - `op_is_div` and `div_by_zero = (b == 0)`;
  - counter = 31.
- Then go to CALC.
- CALC, multiply: one shift-add step per cycle on a 64-bit accumulator.
- CALC, divide: one restoring-division step per cycle (shift the remainder, trial subtract, set a quotient bit).
- CALC: counter decrements each cycle; leave for FIX when the counter is 0, so CALC lasts exactly 32 cycles.
- FIX, sign fixup:
  - multiply: negate the 64-bit product if `sa ^ sb`;
  - divide: negate the quotient if `sa ^ sb`, negate the remainder if `sa`.
- FIX, writeback:
  - multiply: `{HI, LO} <=` product;
  - divide: `LO <=` quotient, `HI <=` remainder;
  - `done <= 1`; go to IDLE.
- Divide by zero (signed or unsigned): `LO = 32'hFFFF_FFFF`, `HI = a`. No sign fixup is applied.
- Signed edge case: DIV `0x80000000 / 0xFFFFFFFF` gives LO=0x80000000, HI=0, with no trap.
- Any other `alu_control` with `start` is ignored: `busy` stays 0 and HI/LO are unchanged.
- MTHI/MTLO are honored only in IDLE. In CALC/FIX they are ignored; the stall guarantees they are never issued there.
- `hi_we`/`lo_we` and `accept` in the same IDLE cycle: the MT write lands now, and the result overwrites it 34 cycles later.
- `flush` in CALC or FIX: return to IDLE next edge. HI/LO are unchanged and no `done` pulse occurs.
- `flush` takes priority over accept and over FIX writeback.
- `start` while busy is ignored. The stalled instruction is held by the pipeline, not queued.

## Timing
- Reset values: state=IDLE, HI=0, LO=0, `done`=0, counter=0. `busy`=0 unless `start` is asserted with a mul/div code.
- Accept sampled at edge k. CALC covers cycles k+1..k+32, FIX is cycle k+33.
- HI/LO are written at edge k+34 and `done`=1 for cycle k+34 only.
- `busy` is 1 from cycle k (combinational accept) through cycle k+33 and is 0 in cycle k+34.
- A back-to-back accept is possible in cycle k+34.
- `hi`/`lo` are direct register outputs; an MFHI in cycle k+34 sees the new value.
- `rst` mid-operation clears everything immediately, asynchronously.

## Structure
- Add `MULT_CONTROL`, `MULTU_CONTROL`, `DIV_CONTROL`, `DIVU_CONTROL` (distinct 5-bit codes) to `defines2.vh`, alongside the existing ALU control codes.
- Add the state encodings IDLE/CALC/FIX to `defines2.vh`.
- One natural sub-module: `muldiv_core`, the 32-step shift-add/restoring datapath with counter.
- `hilo_muldiv` owns the FSM, sign handling, flush, and the HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFF, b=2 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE, `done` pulses once, `busy` high 34 cycles counting the accept cycle.
- MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=0x00000007.
- MTHI 0x1234 in IDLE, then MULT 3*4 -> HI=0x1234 until the result edge, then HI=0, LO=12.
- `flush` in cycle k+10 of a DIV -> state IDLE at k+11, HI/LO unchanged, no `done`; a new MULT accepted at k+11 completes normally.
- Assert `rst` at cycle k+20 -> HI=LO=0, `busy`=0 at once; `start` with the ADD control code -> `busy` stays 0.
